// File: rtl/ssd1306_pkg.sv
// Shared types and command-decode constants for the SSD1306 SPI receive model.
// Holds the receiver state encoding and the page/column command patterns.
package ssd1306_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DECODE
   } state_t;

   localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
   localparam logic [7:0] CMD_PAGE_MASK   = 8'hF8;
   localparam logic [7:0] CMD_COL_LO_BASE = 8'h00;
   localparam logic [7:0] CMD_COL_HI_BASE = 8'h10;
   localparam logic [7:0] CMD_NIBBLE_MASK = 8'hF0;

endpackage

// File: rtl/ssd1306_spi_rx_sync_edge.sv
// Multi-stage synchronizer for a bundle of asynchronous inputs, plus a
// rising-edge detector on one selected bit of the synchronized bundle.
module spi_sync_edge #(
   parameter int               SYNC_STAGES = 2,
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter int               EDGE_BIT    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic             edge_rise
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] stage_d [SYNC_STAGES];
   logic             edge_prev_q;
   logic             edge_prev_d;

   always_comb begin
      stage_d[0] = async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      edge_prev_d = sync_out[EDGE_BIT];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= RESET_VAL;
         end
         edge_prev_q <= RESET_VAL[EDGE_BIT];
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
         edge_prev_q <= edge_prev_d;
      end
   end

   assign sync_out  = stage_q[SYNC_STAGES-1];
   assign edge_rise = sync_out[EDGE_BIT] & ~edge_prev_q;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// Receive side of an SSD1306 controller: deserializes the SPI stream, decodes
// page/column commands and emits one GDDRAM write strobe per data byte.
module ssd1306_spi_rx
   import ssd1306_pkg::*;
#(
   parameter  int SYNC_STAGES = 2,
   parameter  int NUM_COLS    = 128,
   parameter  int NUM_PAGES   = 8,
   localparam int PAGE_W      = $clog2(NUM_PAGES),
   localparam int COL_W       = $clog2(NUM_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   input  logic              spi_dc,
   output logic              wr_en,
   output logic [PAGE_W-1:0] wr_page,
   output logic [COL_W-1:0]  wr_col,
   output logic [7:0]        wr_data,
   output logic              cmd_valid,
   output logic [7:0]        cmd_byte,
   output logic              frame_err,
   output logic              busy
);

   logic [3:0] sync_bus;
   logic       sck_rise;
   logic       mosi_s;
   logic       cs_n_s;
   logic       dc_s;

   // Bundle order {dc, cs_n, mosi, sck}; cs_n resets high so reset reads as deselected.
   spi_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .WIDTH      (4),
      .RESET_VAL  (4'b0100),
      .EDGE_BIT   (0)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in ({spi_dc, spi_cs_n, spi_mosi, spi_sck}),
      .sync_out (sync_bus),
      .edge_rise(sck_rise)
   );

   assign mosi_s = sync_bus[1];
   assign cs_n_s = sync_bus[2];
   assign dc_s   = sync_bus[3];

   state_t             state_q, state_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         byte_q, byte_d;
   logic               dc_q, dc_d;
   logic [PAGE_W-1:0]  page_q, page_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               wr_en_q, wr_en_d;
   logic [PAGE_W-1:0]  wr_page_q, wr_page_d;
   logic [COL_W-1:0]   wr_col_q, wr_col_d;
   logic [7:0]         wr_data_q, wr_data_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic [7:0]         cmd_byte_q, cmd_byte_d;
   logic               frame_err_q, frame_err_d;
   logic [7:0]         shifted;

   assign shifted = {shift_q[6:0], mosi_s};

   // Strobes are registered on the 8th edge; address state updates one cycle later in DECODE.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      dc_d        = dc_q;
      page_d      = page_q;
      col_d       = col_q;
      wr_en_d     = 1'b0;
      wr_page_d   = wr_page_q;
      wr_col_d    = wr_col_q;
      wr_data_d   = wr_data_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            bit_cnt_d = 3'd0;
            if (!cs_n_s) begin
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (sck_rise && bit_cnt_q == 3'd7) begin
               shift_d   = shifted;
               byte_d    = shifted;
               dc_d      = dc_s;
               bit_cnt_d = 3'd0;
               state_d   = DECODE;
               if (dc_s) begin
                  wr_en_d   = 1'b1;
                  wr_page_d = page_q;
                  wr_col_d  = col_q;
                  wr_data_d = shifted;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = shifted;
               end
            end else if (cs_n_s) begin
               frame_err_d = (bit_cnt_q != 3'd0);
               bit_cnt_d   = 3'd0;
               state_d     = IDLE;
            end else if (sck_rise) begin
               shift_d   = shifted;
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end

         DECODE: begin
            if (!dc_q) begin
               if ((byte_q & CMD_PAGE_MASK) == CMD_PAGE_BASE) begin
                  page_d = byte_q[PAGE_W-1:0];
               end else if ((byte_q & CMD_NIBBLE_MASK) == CMD_COL_LO_BASE) begin
                  col_d = {col_q[COL_W-1:4], byte_q[3:0]};
               end else if ((byte_q & CMD_NIBBLE_MASK) == CMD_COL_HI_BASE) begin
                  col_d = {byte_q[COL_W-5:0], col_q[3:0]};
               end
            end else begin
               col_d = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
            end

            // An edge arriving during decode is the first bit of the next byte.
            if (cs_n_s) begin
               bit_cnt_d = 3'd0;
               state_d   = IDLE;
            end else begin
               state_d = SHIFT;
               if (sck_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = 3'd1;
               end else begin
                  bit_cnt_d = 3'd0;
               end
            end
         end

         default: begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         byte_q      <= 8'd0;
         dc_q        <= 1'b0;
         page_q      <= '0;
         col_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_page_q   <= '0;
         wr_col_q    <= '0;
         wr_data_q   <= 8'd0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= 8'd0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_q      <= byte_d;
         dc_q        <= dc_d;
         page_q      <= page_d;
         col_q       <= col_d;
         wr_en_q     <= wr_en_d;
         wr_page_q   <= wr_page_d;
         wr_col_q    <= wr_col_d;
         wr_data_q   <= wr_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_page   = wr_page_q;
   assign wr_col    = wr_col_q;
   assign wr_data   = wr_data_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_byte  = cmd_byte_q;
   assign frame_err = frame_err_q;
   assign busy      = ~cs_n_s;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Self-checking bench for ssd1306_spi_rx: drives SPI byte streams and checks
// the observed write/command/error strobes against a behavioural display model.
module tb_ssd1306_spi_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_dc = 1'b0;
   logic       wr_en;
   logic [2:0] wr_page;
   logic [6:0] wr_col;
   logic [7:0] wr_data;
   logic       cmd_valid;
   logic [7:0] cmd_byte;
   logic       frame_err;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [17:0] got_wr[$];
   logic [7:0]  got_cmd[$];
   int          got_ferr = 0;
   logic [17:0] exp_wr[$];
   logic [7:0]  exp_cmd[$];
   int          m_page = 0;
   int          m_col  = 0;

   ssd1306_spi_rx dut (
      .clk      (clk),
      .rst      (rst),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n),
      .spi_dc   (spi_dc),
      .wr_en    (wr_en),
      .wr_page  (wr_page),
      .wr_col   (wr_col),
      .wr_data  (wr_data),
      .cmd_valid(cmd_valid),
      .cmd_byte (cmd_byte),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) got_wr.push_back({wr_page, wr_col, wr_data});
      if (cmd_valid) got_cmd.push_back(cmd_byte);
      if (frame_err) got_ferr++;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Display model: what the controller should do with a completed byte.
   task automatic model_byte(input bit d, input logic [7:0] b);
      logic [2:0] p;
      logic [6:0] c;
      if (d) begin
         p = 3'(m_page);
         c = 7'(m_col);
         exp_wr.push_back({p, c, b});
         m_col = (m_col + 1) % 128;
      end else begin
         exp_cmd.push_back(b);
         if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b) - 'hB0;
         else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + int'(b);
         else if (b >= 8'h10 && b <= 8'h1F) m_col = (int'(b) % 8) * 16 + (m_col % 16);
      end
   endtask

   task automatic send_bits(input bit d, input logic [7:0] b, input int nbits, input int half);
      spi_dc = d;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = b[i];
         idle(half);
         spi_sck = 1'b1;
         idle(half);
         spi_sck = 1'b0;
      end
   endtask

   task automatic send_byte(input bit d, input logic [7:0] b, input int half);
      send_bits(d, b, 8, half);
      model_byte(d, b);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      idle(4);
   endtask

   task automatic cs_high();
      spi_cs_n = 1'b1;
      idle(8);
   endtask

   task automatic test_reset();
      idle(4);
      @(negedge clk);
      n_cmp++;
      if ({wr_en, wr_page, wr_col, wr_data, cmd_valid, cmd_byte, frame_err, busy} !== 29'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got %h required 0",
                  {wr_en, wr_page, wr_col, wr_data, cmd_valid, cmd_byte, frame_err, busy});
      end
      rst = 1'b0;
      idle(4);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL idle_busy got %b required 0", busy);
      end
   endtask

   task automatic test_page_select();
      int cb = got_cmd.size();
      int wb = got_wr.size();
      cs_low();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_cs_low got %b required 1", busy);
      end
      send_byte(1'b0, 8'hB3, 3);
      cs_high();
      n_cmp++;
      if (got_cmd.size() - cb != 1 || (got_cmd.size() > cb && got_cmd[cb] !== 8'hB3)) begin
         n_fail++;
         $display("[TB] FAIL page_cmd count %0d required 1", got_cmd.size() - cb);
      end
      n_cmp++;
      if (got_wr.size() != wb) begin
         n_fail++;
         $display("[TB] FAIL page_no_write got %0d writes required 0", got_wr.size() - wb);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL busy_cs_high got %b required 0", busy);
      end
   endtask

   task automatic test_col_data();
      int wb = got_wr.size();
      int eb = exp_wr.size();
      cs_low();
      send_byte(1'b0, 8'h05, 3);
      send_byte(1'b0, 8'h12, 3);
      send_byte(1'b1, 8'hAA, 3);
      send_byte(1'b1, 8'h55, 3);
      cs_high();
      n_cmp++;
      if (got_wr.size() - wb != 2) begin
         n_fail++;
         $display("[TB] FAIL col_data count got %0d required 2", got_wr.size() - wb);
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (got_wr[wb+k] !== exp_wr[eb+k]) begin
               n_fail++;
               $display("[TB] FAIL col_data write%0d got %h required %h", k, got_wr[wb+k], exp_wr[eb+k]);
            end
         end
         n_cmp++;
         if (got_wr[wb] !== {3'd3, 7'h25, 8'hAA}) begin
            n_fail++;
            $display("[TB] FAIL col_data first got %h required %h", got_wr[wb], {3'd3, 7'h25, 8'hAA});
         end
      end
   endtask

   task automatic test_wrap();
      int wb = got_wr.size();
      cs_low();
      send_byte(1'b0, 8'h0F, 3);
      send_byte(1'b0, 8'h17, 3);
      send_byte(1'b1, 8'h01, 3);
      send_byte(1'b1, 8'h02, 3);
      cs_high();
      n_cmp++;
      if (got_wr.size() - wb != 2) begin
         n_fail++;
         $display("[TB] FAIL wrap count got %0d required 2", got_wr.size() - wb);
      end else begin
         n_cmp++;
         if (got_wr[wb] !== {3'd3, 7'd127, 8'h01}) begin
            n_fail++;
            $display("[TB] FAIL wrap_last_col got %h required %h", got_wr[wb], {3'd3, 7'd127, 8'h01});
         end
         n_cmp++;
         if (got_wr[wb+1] !== {3'd3, 7'd0, 8'h02}) begin
            n_fail++;
            $display("[TB] FAIL wrap_col0 got %h required %h", got_wr[wb+1], {3'd3, 7'd0, 8'h02});
         end
      end
   endtask

   task automatic test_abort();
      int wb = got_wr.size();
      int cb = got_cmd.size();
      int fb = got_ferr;
      int eb = exp_wr.size();
      cs_low();
      send_bits(1'b0, 8'hFF, 5, 3);
      cs_high();
      n_cmp++;
      if (got_ferr - fb != 1) begin
         n_fail++;
         $display("[TB] FAIL abort_frame_err got %0d pulses required 1", got_ferr - fb);
      end
      n_cmp++;
      if (got_wr.size() != wb || got_cmd.size() != cb) begin
         n_fail++;
         $display("[TB] FAIL abort_no_strobe got %0d wr %0d cmd required 0 0",
                  got_wr.size() - wb, got_cmd.size() - cb);
      end
      cs_low();
      send_byte(1'b0, 8'hB1, 3);
      send_byte(1'b1, 8'h3C, 3);
      cs_high();
      n_cmp++;
      if (got_wr.size() - wb != 1 || got_cmd.size() - cb != 1) begin
         n_fail++;
         $display("[TB] FAIL abort_recover got %0d wr %0d cmd required 1 1",
                  got_wr.size() - wb, got_cmd.size() - cb);
      end else begin
         n_cmp++;
         if (got_wr[wb] !== exp_wr[eb] || got_wr[wb][17:15] !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL abort_page1 got %h required %h", got_wr[wb], exp_wr[eb]);
         end
      end
   endtask

   task automatic test_reset_mid_byte();
      int wb;
      int fb = got_ferr;
      cs_low();
      send_bits(1'b1, 8'hF0, 4, 3);
      rst = 1'b1;
      idle(1);
      @(negedge clk);
      n_cmp++;
      if ({wr_en, wr_page, wr_col, wr_data, cmd_valid, cmd_byte, frame_err, busy} !== 29'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_outputs got %h required 0",
                  {wr_en, wr_page, wr_col, wr_data, cmd_valid, cmd_byte, frame_err, busy});
      end
      idle(2);
      rst = 1'b0;
      m_page = 0;
      m_col = 0;
      idle(4);
      wb = got_wr.size();
      send_byte(1'b1, 8'h80, 3);
      cs_high();
      n_cmp++;
      if (got_ferr != fb) begin
         n_fail++;
         $display("[TB] FAIL midreset_frame_err got %0d pulses required 0", got_ferr - fb);
      end
      n_cmp++;
      if (got_wr.size() - wb != 1 || (got_wr.size() > wb && got_wr[wb] !== {3'd0, 7'd0, 8'h80})) begin
         n_fail++;
         $display("[TB] FAIL midreset_write count %0d required 1 of %h", got_wr.size() - wb, {3'd0, 7'd0, 8'h80});
      end
   endtask

   task automatic test_back_to_back();
      int wb;
      int fb = got_ferr;
      logic [7:0] px;
      cs_low();
      send_byte(1'b0, 8'h00, 3);
      send_byte(1'b0, 8'h10, 3);
      wb = got_wr.size();
      for (int i = 0; i < 8; i++) begin
         px = (i % 2 == 0) ? 8'h02 : 8'h42;
         send_byte(1'b1, px, 2);
      end
      cs_high();
      n_cmp++;
      if (got_wr.size() - wb != 8) begin
         n_fail++;
         $display("[TB] FAIL b2b count got %0d required 8", got_wr.size() - wb);
      end else begin
         for (int i = 0; i < 8; i++) begin
            px = (i % 2 == 0) ? 8'h02 : 8'h42;
            n_cmp++;
            if (got_wr[wb+i][14:0] !== {7'(i), px}) begin
               n_fail++;
               $display("[TB] FAIL b2b write%0d got %h required col %0d data %h", i, got_wr[wb+i], i, px);
            end
         end
      end
      n_cmp++;
      if (got_ferr != fb) begin
         n_fail++;
         $display("[TB] FAIL b2b_frame_err got %0d pulses required 0", got_ferr - fb);
      end
   endtask

   task automatic test_random();
      int wb = got_wr.size();
      int cb = got_cmd.size();
      int eb = exp_wr.size();
      int ecb = exp_cmd.size();
      int fb = got_ferr;
      int nw, nc;
      logic [7:0] b;
      bit d;
      cs_low();
      for (int i = 0; i < 60; i++) begin
         d = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       b = 8'hB0 + 8'($urandom_range(0, 7));
            1:       b = 8'($urandom_range(0, 31));
            default: b = 8'($urandom);
         endcase
         send_byte(d, b, $urandom_range(2, 4));
         if ($urandom_range(0, 7) == 0) begin
            cs_high();
            cs_low();
         end
      end
      cs_high();
      nw = exp_wr.size() - eb;
      nc = exp_cmd.size() - ecb;
      n_cmp++;
      if (got_wr.size() - wb != nw || got_cmd.size() - cb != nc) begin
         n_fail++;
         $display("[TB] FAIL rand_counts got %0d wr %0d cmd required %0d %0d",
                  got_wr.size() - wb, got_cmd.size() - cb, nw, nc);
      end else begin
         for (int k = 0; k < nw; k++) begin
            n_cmp++;
            if (got_wr[wb+k] !== exp_wr[eb+k]) begin
               n_fail++;
               $display("[TB] FAIL rand_write%0d got %h required %h", k, got_wr[wb+k], exp_wr[eb+k]);
            end
         end
         for (int k = 0; k < nc; k++) begin
            n_cmp++;
            if (got_cmd[cb+k] !== exp_cmd[ecb+k]) begin
               n_fail++;
               $display("[TB] FAIL rand_cmd%0d got %h required %h", k, got_cmd[cb+k], exp_cmd[ecb+k]);
            end
         end
      end
      n_cmp++;
      if (got_ferr != fb) begin
         n_fail++;
         $display("[TB] FAIL rand_frame_err got %0d pulses required 0", got_ferr - fb);
      end
   endtask

   initial begin
      $display("[TB] starting ssd1306_spi_rx bench");
      test_reset();
      test_page_select();
      test_col_data();
      test_wrap();
      test_abort();
      test_reset_mid_byte();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ssd1306_spi_rx.md
Name: ssd1306_spi_rx

Overview:
- SPI responder that models the receive side of an SSD1306 OLED controller.
- Captures the CS/DC/SCK/MOSI stream produced by the waveform plotter peripheral and decodes page/column addressing commands.
- Emits one GDDRAM write strobe (page, column, byte) per data byte.
- Used as the display-side model in system benches, and as a capture front-end for an on-chip framebuffer mirror.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each SPI input (min 2).
- NUM_COLS, 128, columns per page; column counter wraps at NUM_COLS-1.
- NUM_PAGES, 8, pages; page index width is clog2(NUM_PAGES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI clock, CPOL=0, sampled on rising edge (CPHA=0).
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = data byte.
- wr_en  out  1  one-cycle GDDRAM write strobe.
- wr_page  out  3  page of the current write.
- wr_col  out  7  column of the current write.
- wr_data  out  8  data byte of the current write.
- cmd_valid  out  1  one-cycle strobe for every command byte, including ignored commands.
- cmd_byte  out  8  received command byte.
- frame_err  out  1  one-cycle pulse when CS deasserts mid-byte.
- busy  out  1  high while synchronized CS is asserted.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Input path and edge detect:
  - All four SPI inputs pass through SYNC_STAGES flops.
  - Rising SCK edge = synchronized sck high while its previous sample is low.
  - Required: clk >= 4x SCK frequency. No detection guarantee below that.
- State machine:
  - IDLE: synchronized cs_n high. Bit count 0, shift register held. Go to SHIFT when cs_n is low.
  - SHIFT: on each rising edge, shift_reg <= {shift_reg[6:0], mosi}, bit count +1.
    - On the 8th edge: latch the byte and DC (DC is sampled at the 8th edge), then go to DECODE.
    - If cs_n goes high with bit count in 1..7: pulse frame_err, discard the partial byte, go to IDLE.
    - If cs_n goes high with bit count 0: go to IDLE silently.
  - DECODE (one cycle): perform the decode actions below. Then go to SHIFT if cs_n is low, else IDLE. Bit count restarts at 0.
- Simultaneous 8th edge and CS deassert: the edge wins. The byte completes and decodes; no frame_err.
- An SCK edge during DECODE is still captured as bit 0 of the next byte. Decode must not drop it.
- Decode, DC=0 (command):
  - Always: cmd_valid=1, cmd_byte=byte.
  - 0xB0-0xB7: page <= byte[2:0].
  - 0x00-0x0F: col[3:0] <= byte[3:0].
  - 0x10-0x17: col[6:4] <= byte[2:0].
  - 0x18-0x1F: col[6:4] <= byte[2:0]; bit 3 is ignored.
  - All other commands: no state change.
- Decode, DC=1 (data):
  - wr_en=1, wr_page=page, wr_col=col, wr_data=byte.
  - Then col <= col+1, wrapping NUM_COLS-1 -> 0. Page is unchanged (page addressing mode).
- Latency: wr_en/cmd_valid assert in the clk cycle after the one in which the 8th synchronized rising edge is detected. That is SYNC_STAGES+2 clk cycles after the raw SCK edge.
- Output hold: wr_page, wr_col, wr_data and cmd_byte hold their last values between strobes.
- Reset:
  - All outputs 0.
  - page=0, col=0, bit count 0, state IDLE, synchronizers cleared.
  - Reset mid-byte discards the partial byte with no frame_err.
- Page and column persist across CS deassertion; only rst clears them.

Decomposition:
- ssd1306_pkg holds:
  - state enum {IDLE, SHIFT, DECODE};
  - constants CMD_PAGE_BASE=8'hB0, CMD_PAGE_MASK=8'hF8, CMD_COL_LO_BASE=8'h00, CMD_COL_HI_BASE=8'h10, CMD_NIBBLE_MASK=8'hF0.
- One sub-module: spi_sync_edge. It contains the parameterized synchronizer and rising-edge detector, instantiated once for the bundle {sck, mosi, cs_n, dc}, and outputs synchronized levels plus sck_rise.

Test Plan:
- Page select: CS low, DC=0, send 0xB3 -> cmd_valid once with cmd_byte=0xB3; internal page=3; no wr_en.
- Column + data: send cmds 0x05, 0x12, then DC=1 data 0xAA, 0x55 -> wr_en twice: (page 3, col 0x25, 0xAA), then (3, 0x26, 0x55).
- Wrap: cmds 0x0F, 0x17 (col 127), then data 0x01, 0x02 -> writes at col 127, then col 0; page unchanged.
- Abort: 5 SCK edges, then CS high -> frame_err pulses exactly once; no wr_en/cmd_valid. The next full byte 0xB1 decodes with page=1.
- Reset mid-byte: rst after 4 bits -> all outputs 0, page=col=0. Then DC=1 byte 0x80 -> wr_en with (0, 0, 0x80).
- Back-to-back at minimum ratio (clk=4x SCK), CS held low, DC=1: 8 plotter pixel bytes alternating 0x02/0x42 -> 8 wr_en pulses, cols 0..7, data matches, no frame_err.
